// File: rtl/mac_tx_framer.sv
// ---------------------------------------------------------------------------
// mac_tx_framer
//
// Gigabit Ethernet transmit framer. On an accepted request it emits one
// complete byte-wide GMII frame: 7x 0x55 preamble, 0xD5 SFD, destination MAC,
// source MAC, type field, payload fetched from an external single-port read
// buffer, zero padding up to the 46-byte minimum, and the CRC-32 FCS. The
// frame is followed by an inter-frame gap before the next request is taken.
//
// Ports
//   GMII_TX_CLK  in   125 MHz transmit clock (only clock)
//   reset_n      in   synchronous active-low reset
//   MAC_addr     in   source MAC, sampled at acceptance
//   Dst_MAC      in   destination MAC, sampled at acceptance
//   Tx_len       in   payload length, sampled at acceptance, clamped to 1500
//   Tx_req       in   level request, accepted when the framer is idle
//   Tx_ack       out  one-cycle pulse on acceptance
//   Tx_busy      out  high from acceptance through the end of the IFG
//   Tx_done      out  one-cycle pulse in the first IFG cycle
//   Rd_en        out  payload buffer read enable
//   Rd_Addr      out  payload buffer address (data returns next clock)
//   Rd_data      in   payload buffer read data
//   GMII_TXD     out  transmit byte
//   GMII_TX_EN   out  transmit enable
//   GMII_TX_ER   out  transmit error, tied low
// ---------------------------------------------------------------------------
module mac_tx_framer #(
  parameter int          ADDR_BITS  = 11,
  parameter logic [15:0] ETH_TYPE   = 16'hAA55,
  parameter int          IFG_CYCLES = 12
) (
  input  logic                 GMII_TX_CLK,
  input  logic                 reset_n,
  input  logic [47:0]          MAC_addr,
  input  logic [47:0]          Dst_MAC,
  input  logic [10:0]          Tx_len,
  input  logic                 Tx_req,
  output logic                 Tx_ack,
  output logic                 Tx_busy,
  output logic                 Tx_done,
  output logic                 Rd_en,
  output logic [ADDR_BITS-1:0] Rd_Addr,
  input  logic [7:0]           Rd_data,
  output logic [7:0]           GMII_TXD,
  output logic                 GMII_TX_EN,
  output logic                 GMII_TX_ER
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_SFD  = 3'd2;
  localparam logic [2:0] ST_HDR  = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
  localparam logic [2:0] ST_PAD  = 3'd5;
  localparam logic [2:0] ST_FCS  = 3'd6;
  localparam logic [2:0] ST_IFG  = 3'd7;

  localparam logic [10:0] MAX_LEN     = 11'd1500;
  localparam logic [10:0] MIN_PAYLOAD = 11'd46;
  localparam logic [10:0] PRE_LAST    = 11'd6;
  localparam logic [10:0] HDR_LAST    = 11'd13;
  localparam logic [10:0] FCS_LAST    = 11'd3;
  localparam logic [10:0] IFG_LAST    = 11'(IFG_CYCLES - 1);
  // Address 0 goes out with header byte 12 so that byte 0 lands right
  // after header byte 13 through the one-cycle buffer latency.
  localparam logic [10:0] RD_START    = 11'd12;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      rev8[i] = d[7-i];
    end
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] d);
    for (int i = 0; i < 32; i++) begin
      rev32[i] = d[31-i];
    end
  endfunction

  // MSB-first CRC-32 over one byte, d[7] shifted in first.
  function automatic logic [31:0] crc32_d8(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ ({32{fb}} & CRC_POLY);
    end
    return r;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [10:0] idx, input logic [47:0] dst,
                                          input logic [47:0] src, input logic [15:0] etype);
    case (idx)
      11'd0:   hdr_byte = dst[47:40];
      11'd1:   hdr_byte = dst[39:32];
      11'd2:   hdr_byte = dst[31:24];
      11'd3:   hdr_byte = dst[23:16];
      11'd4:   hdr_byte = dst[15:8];
      11'd5:   hdr_byte = dst[7:0];
      11'd6:   hdr_byte = src[47:40];
      11'd7:   hdr_byte = src[39:32];
      11'd8:   hdr_byte = src[31:24];
      11'd9:   hdr_byte = src[23:16];
      11'd10:  hdr_byte = src[15:8];
      11'd11:  hdr_byte = src[7:0];
      11'd12:  hdr_byte = etype[15:8];
      11'd13:  hdr_byte = etype[7:0];
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  logic [2:0]           state_q, state_d;
  logic [10:0]          cnt_q, cnt_d;
  logic [47:0]          dst_q, dst_d;
  logic [47:0]          src_q, src_d;
  logic [10:0]          len_q, len_d;
  logic [10:0]          pad_q, pad_d;
  logic [31:0]          crc_q, crc_d;
  logic [7:0]           txd_q, txd_d;
  logic                 tx_en_q, tx_en_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_en_q, rd_en_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;

  logic                 accept_s;
  logic [10:0]          len_clamp_s;
  logic [31:0]          fcs_s;
  logic [11:0]          fetch_idx_s;
  logic                 fetch_win_s;

  // Clamp the requested length to the largest legal payload.
  always_comb begin
    if (Tx_len > MAX_LEN) begin
      len_clamp_s = MAX_LEN;
    end else begin
      len_clamp_s = Tx_len;
    end
  end

  // Frame sequencing: state and byte position of the byte on the wire next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    src_d    = src_q;
    len_d    = len_q;
    pad_d    = pad_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Tx_req) begin
          accept_s = 1'b1;
        end else begin
          cnt_d = 11'd0;
        end
      end
      ST_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
          cnt_d   = 11'd0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_SFD: begin
        state_d = ST_HDR;
        cnt_d   = 11'd0;
      end
      ST_HDR: begin
        if (cnt_q == HDR_LAST) begin
          state_d = (len_q != 11'd0) ? ST_DATA : ST_PAD;
          cnt_d   = 11'd0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == len_q - 11'd1) begin
          state_d = (pad_q != 11'd0) ? ST_PAD : ST_FCS;
          cnt_d   = 11'd0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_PAD: begin
        if (cnt_q == pad_q - 11'd1) begin
          state_d = ST_FCS;
          cnt_d   = 11'd0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_FCS: begin
        if (cnt_q == FCS_LAST) begin
          state_d = ST_IFG;
          cnt_d   = 11'd0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_IFG: begin
        // The last gap cycle is where the framer turns idle, so a held
        // request starts the next preamble with no extra dead cycle.
        if (cnt_q == IFG_LAST) begin
          if (Tx_req) begin
            accept_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 11'd0;
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 11'd0;
      end
    endcase

    if (accept_s) begin
      state_d = ST_PRE;
      cnt_d   = 11'd0;
      dst_d   = Dst_MAC;
      src_d   = MAC_addr;
      len_d   = len_clamp_s;
      pad_d   = (len_clamp_s < MIN_PAYLOAD) ? (MIN_PAYLOAD - len_clamp_s) : 11'd0;
    end else begin
      pad_d = pad_q;
    end
  end

  // Next output byte, CRC accumulation and payload prefetch, all keyed off
  // the next state so that every output leaves a flop.
  always_comb begin
    txd_d       = 8'h00;
    tx_en_d     = 1'b1;
    crc_d       = crc_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    fcs_s       = rev32(~crc_q);
    fetch_idx_s = 12'd0;
    fetch_win_s = 1'b0;
    case (state_d)
      ST_IDLE: tx_en_d = 1'b0;
      ST_PRE:  txd_d   = 8'h55;
      ST_SFD: begin
        txd_d = 8'hD5;
        crc_d = CRC_INIT;
      end
      ST_HDR: begin
        txd_d = hdr_byte(cnt_d, dst_q, src_q, ETH_TYPE);
        crc_d = crc32_d8(rev8(txd_d), crc_q);
      end
      ST_DATA: begin
        txd_d = Rd_data;
        crc_d = crc32_d8(rev8(txd_d), crc_q);
      end
      ST_PAD: begin
        txd_d = 8'h00;
        crc_d = crc32_d8(rev8(txd_d), crc_q);
      end
      ST_FCS: begin
        case (cnt_d[1:0])
          2'd0:    txd_d = fcs_s[7:0];
          2'd1:    txd_d = fcs_s[15:8];
          2'd2:    txd_d = fcs_s[23:16];
          2'd3:    txd_d = fcs_s[31:24];
          default: txd_d = 8'h00;
        endcase
      end
      ST_IFG:  tx_en_d = 1'b0;
      default: tx_en_d = 1'b0;
    endcase

    // Fetch index = payload byte that will be on the wire two cycles later.
    if (state_d == ST_HDR && cnt_d >= RD_START) begin
      fetch_win_s = 1'b1;
      fetch_idx_s = {1'b0, cnt_d - RD_START};
    end else if (state_d == ST_DATA) begin
      fetch_win_s = 1'b1;
      fetch_idx_s = {1'b0, cnt_d} + 12'd2;
    end else begin
      fetch_win_s = 1'b0;
    end

    if (fetch_win_s && (fetch_idx_s < {1'b0, len_q})) begin
      rd_en_d   = 1'b1;
      rd_addr_d = ADDR_BITS'(fetch_idx_s);
    end else begin
      rd_en_d = 1'b0;
    end
  end

  // Handshake and status pulses.
  always_comb begin
    ack_d  = accept_s;
    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_IFG && cnt_d == 11'd0) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge GMII_TX_CLK) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 11'd0;
      dst_q     <= 48'd0;
      src_q     <= 48'd0;
      len_q     <= 11'd0;
      pad_q     <= 11'd0;
      crc_q     <= 32'd0;
      txd_q     <= 8'h00;
      tx_en_q   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      len_q     <= len_d;
      pad_q     <= pad_d;
      crc_q     <= crc_d;
      txd_q     <= txd_d;
      tx_en_q   <= tx_en_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign Tx_ack     = ack_q;
  assign Tx_busy    = busy_q;
  assign Tx_done    = done_q;
  assign Rd_en      = rd_en_q;
  assign Rd_Addr    = rd_addr_q;
  assign GMII_TXD   = txd_q;
  assign GMII_TX_EN = tx_en_q;
  assign GMII_TX_ER = 1'b0;

endmodule

// File: tb/tb_mac_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_mac_tx_framer
//
// Self-checking bench for mac_tx_framer. A table of frame requests with
// hand-computed frame lengths and read counts is applied in a loop; the
// expected byte stream is built independently (reflected CRC-32). Separate
// sequences cover back-to-back frames and a reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_mac_tx_framer;

  localparam int ADDR_BITS = 11;
  localparam int IFG       = 12;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [47:0]          MAC_addr;
  logic [47:0]          Dst_MAC;
  logic [10:0]          Tx_len;
  logic                 Tx_req;
  logic                 Tx_ack;
  logic                 Tx_busy;
  logic                 Tx_done;
  logic                 Rd_en;
  logic [ADDR_BITS-1:0] Rd_Addr;
  logic [7:0]           Rd_data;
  logic [7:0]           GMII_TXD;
  logic                 GMII_TX_EN;
  logic                 GMII_TX_ER;

  always #4 clk = ~clk;

  mac_tx_framer #(
    .ADDR_BITS (ADDR_BITS),
    .ETH_TYPE  (16'hAA55),
    .IFG_CYCLES(IFG)
  ) dut (
    .GMII_TX_CLK(clk),
    .reset_n    (reset_n),
    .MAC_addr   (MAC_addr),
    .Dst_MAC    (Dst_MAC),
    .Tx_len     (Tx_len),
    .Tx_req     (Tx_req),
    .Tx_ack     (Tx_ack),
    .Tx_busy    (Tx_busy),
    .Tx_done    (Tx_done),
    .Rd_en      (Rd_en),
    .Rd_Addr    (Rd_Addr),
    .Rd_data    (Rd_data),
    .GMII_TXD   (GMII_TXD),
    .GMII_TX_EN (GMII_TX_EN),
    .GMII_TX_ER (GMII_TX_ER)
  );

  // Payload buffer: one-cycle read latency; junk (stand-in for X) when no read.
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    Rd_data <= Rd_en ? mem[Rd_Addr] : 8'hA5;
  end

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [10:0] len;
    int          exp_cycles;
    int          exp_rd;
  } vec_t;

  vec_t vecs [7];

  int checks = 0;
  int errors = 0;

  // Per-cycle bookkeeping, updated only by tick().
  int                   ack_cnt = 0;
  int                   done_cnt = 0;
  int                   rd_cnt = 0;
  int                   rd_next = 0;
  int                   rd_seq_err = 0;
  int                   hold_err = 0;
  int                   lead_err = 0;
  int                   cur_len = 0;
  logic                 prev_rstn = 1'b0;
  logic [ADDR_BITS-1:0] addr_prev = '0;
  logic                 en_h [3];
  logic [ADDR_BITS-1:0] addr_h [3];

  logic [7:0] rx    [0:2047];
  logic [7:0] exp_b [0:2047];
  int         exp_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ack_cnt  += int'(Tx_ack);
    done_cnt += int'(Tx_done);
    en_h[2]   = en_h[1];
    en_h[1]   = en_h[0];
    en_h[0]   = Rd_en;
    addr_h[2] = addr_h[1];
    addr_h[1] = addr_h[0];
    addr_h[0] = Rd_Addr;
    if (Rd_en) begin
      rd_cnt++;
      if (int'(Rd_Addr) != rd_next) rd_seq_err++;
      rd_next++;
    end else if (reset_n && prev_rstn && (Rd_Addr !== addr_prev)) begin
      hold_err++;
    end
    addr_prev = Rd_Addr;
    prev_rstn = reset_n;
  endtask

  function automatic logic [31:0] crc_refl(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = d[31-k];
    return r;
  endfunction

  function automatic void push_exp(input logic [7:0] b);
    exp_b[exp_n] = b;
    exp_n++;
  endfunction

  function automatic void build_expected(input logic [47:0] dst, input logic [47:0] src,
                                         input logic [10:0] len);
    int          l;
    logic [31:0] c;
    exp_n = 0;
    l = (len > 11'd1500) ? 1500 : int'(len);
    for (int k = 0; k < 7; k++) push_exp(8'h55);
    push_exp(8'hD5);
    for (int k = 0; k < 6; k++) push_exp(dst[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) push_exp(src[47-8*k -: 8]);
    push_exp(8'hAA);
    push_exp(8'h55);
    for (int k = 0; k < l; k++) push_exp(mem[k]);
    for (int k = l; k < 46; k++) push_exp(8'h00);
    c = 32'hFFFF_FFFF;
    for (int k = 8; k < exp_n; k++) c = crc_refl(c, exp_b[k]);
    c = ~c;
    push_exp(c[7:0]);
    push_exp(c[15:8]);
    push_exp(c[23:16]);
    push_exp(c[31:24]);
  endfunction

  // Collect bytes while TX_EN is high, starting at a cycle showing byte 0.
  task automatic capture(output int n);
    n = 0;
    while (GMII_TX_EN === 1'b1 && n < 2000) begin
      rx[n] = GMII_TXD;
      if (n >= 22 && n < 22 + cur_len) begin
        if (!(en_h[2] === 1'b1 && addr_h[2] === ADDR_BITS'(n - 22))) lead_err++;
      end
      n++;
      tick();
    end
  endtask

  task automatic compare_frame(input string tag, input int n);
    int          mism;
    int          first;
    logic [31:0] c;
    mism  = 0;
    first = -1;
    for (int k = 0; k < exp_n; k++) begin
      if (k >= n || rx[k] !== exp_b[k]) begin
        mism++;
        if (first < 0) first = k;
      end
    end
    check({tag, " byte mismatches"}, mism, 0);
    if (first >= 0 && first < n)
      $display("  %s first differing byte %0d: got %02h want %02h", tag, first, rx[first], exp_b[first]);
    c = 32'hFFFF_FFFF;
    for (int k = 8; k < n; k++) c = crc_refl(c, rx[k]);
    check({tag, " crc residue"}, bitrev32(c), 32'hC704_DD7B);
  endtask

  // At the first cycle after the last FCS byte: done pulse, idle bus, busy span.
  task automatic check_ifg(input string tag);
    int b;
    check({tag, " done pulse"}, Tx_done, 1);
    check({tag, " bus idle after fcs"}, {23'd0, GMII_TX_EN, GMII_TXD}, 32'd0);
    b = 0;
    while (Tx_busy === 1'b1 && b < 40) begin
      b++;
      tick();
    end
    check({tag, " busy cycles in ifg"}, b, IFG);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int n;
    int a0;
    int d0;
    int r0;
    Dst_MAC  = v.dst;
    MAC_addr = v.src;
    Tx_len   = v.len;
    Tx_req   = 1'b1;
    a0 = ack_cnt;
    d0 = done_cnt;
    r0 = rd_cnt;
    rd_next    = 0;
    rd_seq_err = 0;
    lead_err   = 0;
    cur_len    = (v.len > 11'd1500) ? 1500 : int'(v.len);
    build_expected(v.dst, v.src, v.len);
    tick();
    check({tag, " ack"}, {Tx_ack, Tx_busy}, 2'b11);
    check({tag, " first byte"}, {GMII_TX_EN, GMII_TXD}, {1'b1, 8'h55});
    // Later input changes must not disturb the frame in progress.
    Tx_req   = 1'b0;
    Dst_MAC  = ~v.dst;
    MAC_addr = 48'h0;
    Tx_len   = 11'd3;
    capture(n);
    check({tag, " tx_en cycles"}, n, v.exp_cycles);
    compare_frame(tag, n);
    check({tag, " rd_en cycles"}, rd_cnt - r0, v.exp_rd);
    check({tag, " rd address order"}, rd_seq_err, 0);
    check({tag, " rd lead of 2"}, lead_err, 0);
    check_ifg(tag);
    check({tag, " ack count"}, ack_cnt - a0, 1);
    check({tag, " done count"}, done_cnt - d0, 1);
  endtask

  initial begin
    int   n;
    int   g;
    int   a0;
    int   d0;
    int   r0;
    vec_t vb;

    vecs[0] = '{dst: 48'hFFFF_FFFF_FFFF, src: 48'h4B45_5900_0001, len: 11'd46,   exp_cycles: 72,   exp_rd: 46};
    vecs[1] = '{dst: 48'h0011_2233_4455, src: 48'h4B45_5900_0001, len: 11'd1,    exp_cycles: 72,   exp_rd: 1};
    vecs[2] = '{dst: 48'h0011_2233_4455, src: 48'h4B45_5900_0002, len: 11'd0,    exp_cycles: 72,   exp_rd: 0};
    vecs[3] = '{dst: 48'h0A1B_2C3D_4E5F, src: 48'h4B45_5900_0003, len: 11'd60,   exp_cycles: 86,   exp_rd: 60};
    vecs[4] = '{dst: 48'h0A1B_2C3D_4E5F, src: 48'h4B45_5900_0004, len: 11'd45,   exp_cycles: 72,   exp_rd: 45};
    vecs[5] = '{dst: 48'hFFFF_FFFF_FFFF, src: 48'h4B45_5900_0001, len: 11'd1500, exp_cycles: 1526, exp_rd: 1500};
    vecs[6] = '{dst: 48'hFFFF_FFFF_FFFF, src: 48'h4B45_5900_0001, len: 11'd2000, exp_cycles: 1526, exp_rd: 1500};
    vb      = '{dst: 48'h0A0B_0C0D_0E0F, src: 48'h0200_0000_0002, len: 11'd10,   exp_cycles: 72,   exp_rd: 10};

    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
    for (int i = 0; i < 3; i++) begin
      en_h[i]   = 1'b0;
      addr_h[i] = '0;
    end

    reset_n  = 1'b0;
    Tx_req   = 1'b0;
    Dst_MAC  = 48'h0;
    MAC_addr = 48'h0;
    Tx_len   = 11'd0;
    repeat (3) tick();
    check("reset outputs",
          {7'd0, Tx_ack, Tx_busy, Tx_done, Rd_en, Rd_Addr, GMII_TXD, GMII_TX_EN, GMII_TX_ER}, 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: request held across the gap, new fields for frame 2.
    a0 = ack_cnt;
    d0 = done_cnt;
    Dst_MAC  = vecs[0].dst;
    MAC_addr = vecs[0].src;
    Tx_len   = vecs[0].len;
    Tx_req   = 1'b1;
    build_expected(vecs[0].dst, vecs[0].src, vecs[0].len);
    cur_len  = 46;
    rd_next  = 0;
    rd_seq_err = 0;
    lead_err = 0;
    tick();
    check("b2b ack1", Tx_ack, 1);
    Dst_MAC  = vb.dst;
    MAC_addr = vb.src;
    Tx_len   = vb.len;
    capture(n);
    check("b2b f1 tx_en cycles", n, 72);
    compare_frame("b2b f1", n);
    g = 0;
    while (GMII_TX_EN !== 1'b1 && g < 40) begin
      g++;
      tick();
    end
    check("b2b gap cycles", g, IFG);
    check("b2b ack2", {Tx_ack, Tx_busy}, 2'b11);
    Tx_req = 1'b0;
    build_expected(vb.dst, vb.src, vb.len);
    cur_len  = 10;
    rd_next  = 0;
    lead_err = 0;
    r0 = rd_cnt;
    capture(n);
    check("b2b f2 tx_en cycles", n, vb.exp_cycles);
    compare_frame("b2b f2", n);
    check("b2b f2 rd_en cycles", rd_cnt - r0, vb.exp_rd);
    check("b2b f2 rd lead of 2", lead_err, 0);
    check_ifg("b2b f2");
    check("b2b ack count", ack_cnt - a0, 2);
    check("b2b done count", done_cnt - d0, 2);

    // Reset while payload byte 10 is on the wire.
    Dst_MAC  = vecs[0].dst;
    MAC_addr = vecs[0].src;
    Tx_len   = vecs[0].len;
    Tx_req   = 1'b1;
    tick();
    check("midrst ack", Tx_ack, 1);
    Tx_req = 1'b0;
    repeat (32) tick();
    check("midrst data byte 10", {GMII_TX_EN, GMII_TXD}, {1'b1, 8'h0A});
    reset_n = 1'b0;
    tick();
    check("midrst outputs",
          {7'd0, Tx_ack, Tx_busy, Tx_done, Rd_en, Rd_Addr, GMII_TXD, GMII_TX_EN, GMII_TX_ER}, 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();
    check("midrst idle after release", {Tx_busy, GMII_TX_EN}, 2'b00);
    run_frame(vecs[0], "after reset");

    check("rd addr hold", hold_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
